masked_gf4_inv_prep: RTL and testbench
======================================

Name: masked_gf4_inv_prep

Overview:
- Masked stage directly upstream of the GF(2^4) inverter in the 5-stage DOM AES S-box.
- Takes the shared GF(2^8) element after the input basis change and splits it into high nibble Ah and low nibble Al.
- Computes the shared inverter input E = sqsc(Ah^Al) ^ Ah*Al with one DOM-independent register stage.
- Delays the Ah/Al shares so they arrive aligned with the inverter output for the downstream GF(2^4) multipliers.

Parameters:
- SHARES, 2, number of masking shares (d+1); legal values ≥2.
- INV_LATENCY, 2, cycle latency of the downstream inverter; legal values ≥0.

Ports:
- ClkxCI  in  1  clock; all state updates on its rising edge.
- RstxBI  in  1  reset, synchronous, active-low.
- _XxDI  in  8*SHARES  input shares; share i at [8i +: 8]; Ah_i=[8i+4 +: 4], Al_i=[8i +: 4].
- _ZxDI  in  2*SHARES*(SHARES-1)  fresh randomness; pair (i<j), lexicographic index k, uses [4k +: 4].
- InValidxSI  in  1  tags _XxDI as carrying a valid element this cycle.
- _ExDO  out  4*SHARES  shares of E; share i at [4i +: 4].
- _AhxDO  out  4*SHARES  Ah shares delayed 1+INV_LATENCY cycles.
- _AlxDO  out  4*SHARES  Al shares delayed 1+INV_LATENCY cycles.
- EValidxSO  out  1  _ExDO carries a valid E.
- AValidxSO  out  1  _AhxDO/_AlxDO carry valid data.

Behaviour:
- Field ops are normal-basis (Canright). Bit numbering is 1 = MSB of a 2-bit element.
  - gf2_mul(a,b): p=(a1^a0)&(b1^b0); result {a1&b1^p, a0&b0^p}.
  - gf2_scl_n(a) = {a1^a0, a1}.
  - gf4_mul(a,b): ph=gf2_mul(a[3:2],b[3:2]); pl=gf2_mul(a[1:0],b[1:0]); p=gf2_scl_n(gf2_mul(a[3:2]^a[1:0], b[3:2]^b[1:0])); result {ph^p, pl^p}.
  - gf4_sqsc(x), with A=x[3:2], B=x[1:0]: result {A0^B0, A1^B1, B1, B0^B1}.
- DOM inner-domain term for share i: T_ii = gf4_sqsc(Ah_i^Al_i) ^ gf4_mul(Ah_i,Al_i). This is linear/local per share and is registered.
- DOM cross-domain terms for each pair i<j with randomness Z_k:
  - T_ij = gf4_mul(Ah_i,Al_j) ^ Z_k, registered into domain i.
  - T_ji = gf4_mul(Ah_j,Al_i) ^ Z_k, registered into domain j.
  - Each product term is XORed with Z_k before its register, never after.
- E_i = XOR of all registered T_i*. Only the XOR compression follows the registers.
- Latency is 1 cycle: the data at edge n yields E at edge n+1.
- Ah/Al delay line: 1+INV_LATENCY register stages per share. It is free-running, with no stall and no enable.
- Valid pipeline:
  - EValidxSO is InValidxSI delayed 1 cycle.
  - AValidxSO is InValidxSI delayed 1+INV_LATENCY cycles.
  - Data registers capture every cycle regardless of valid.
- Reset (RstxBI=0 at an edge):
  - All data registers, delay stages and valid flags are set to 0.
  - Outputs are 0 from the following cycle.
  - Reset wins over a simultaneous InValidxSI.
  - In-flight elements are discarded.
  - The first valid output after release appears exactly at the nominal latency.
- Back-to-back valids are accepted every cycle with no bubbles. The valid pattern is reproduced exactly on both valid outputs.
- Unmasked correctness: XOR over shares of E equals gf4_sqsc(Ah^Al)^gf4_mul(Ah,Al) of the unmasked X, for any Z.

Decomposition:
- Shared include gf_ops.vh holds the functions gf2_mul, gf2_scl_n, gf4_mul, gf4_sqsc and the pair-index helper k(i,j).
- Sub-module dom_gf4_sqscmul holds the DOM core: term generation, randomness, registers and compression, with parameter SHARES.
- The delay line and valid pipeline live in the top module.

Test Plan:
- SHARES=2, X unmasked 0x10 (shares 0x10/0x00), Z=0 → E shares XOR = 0x9 one cycle later; EValidxSO=1.
- X unmasked 0x11, random masks and random Z → E reconstructs to 0xD; AhxDO/AlxDO reconstruct to 0x1/0x1 three cycles after input; AValidxSO pulses at cycle 3.
- 256 back-to-back valid inputs with random masks and Z, SHARES=2 and 3 → every reconstructed E matches the golden model; valid outputs are continuous with no gaps.
- Assert reset mid-stream while valids are in flight → EValidxSO=AValidxSO=0 and all outputs 0 one cycle later; the first post-reset input emerges at nominal latency.
- RstxBI=0 together with InValidxSI=1 → no valid ever emitted for that input.
- INV_LATENCY=0 → Ah/Al and AValidxSO are aligned with E and EValidxSO (latency 1).

Source files
------------

// File: rtl/masked_gf4_inv_prep_pkg.sv
// Normal-basis GF(2^2)/GF(2^4) helpers shared by the masked inverter-prep stage.
package masked_gf4_inv_prep_pkg;

    localparam int GF4_W = 4;

    function automatic logic [1:0] gf2_mul(input logic [1:0] a, input logic [1:0] b);
        logic p;
        p = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ p, (a[0] & b[0]) ^ p};
    endfunction

    function automatic logic [1:0] gf2_scl_n(input logic [1:0] a);
        return {a[1] ^ a[0], a[1]};
    endfunction

    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] ph;
        logic [1:0] pl;
        logic [1:0] p;
        ph = gf2_mul(a[3:2], b[3:2]);
        pl = gf2_mul(a[1:0], b[1:0]);
        p  = gf2_scl_n(gf2_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]));
        return {ph ^ p, pl ^ p};
    endfunction

    // Square-and-scale by nu, A = x[3:2], B = x[1:0].
    function automatic logic [3:0] gf4_sqsc(input logic [3:0] x);
        return {x[2] ^ x[0], x[3] ^ x[1], x[1], x[0] ^ x[1]};
    endfunction

    // Lexicographic index of share pair (i<j) among n shares.
    function automatic int pair_idx(input int i, input int j, input int n);
        return i * n - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/masked_gf4_inv_prep_dom.sv
// DOM core computing shares of sqsc(Ah^Al) ^ Ah*Al with one register stage.
module dom_gf4_sqscmul
    import masked_gf4_inv_prep_pkg::*;
#(
    parameter int SHARES = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [GF4_W*SHARES-1:0]         ah_i,
    input  logic [GF4_W*SHARES-1:0]         al_i,
    input  logic [2*SHARES*(SHARES-1)-1:0]  z_i,
    output logic [GF4_W*SHARES-1:0]         e_o
);

    logic [3:0] t_d [SHARES][SHARES];
    logic [3:0] t_q [SHARES][SHARES];

    // Fresh randomness is folded in before the register so no unmasked cross product is ever stored.
    always_comb begin
        t_d = '{default: '0};
        for (int i = 0; i < SHARES; i++) begin
            for (int j = 0; j < SHARES; j++) begin
                if (i == j) begin
                    t_d[i][j] = gf4_sqsc(ah_i[4*i +: 4] ^ al_i[4*i +: 4])
                              ^ gf4_mul(ah_i[4*i +: 4], al_i[4*i +: 4]);
                end else if (i < j) begin
                    t_d[i][j] = gf4_mul(ah_i[4*i +: 4], al_i[4*j +: 4])
                              ^ z_i[4*pair_idx(i, j, SHARES) +: 4];
                end else begin
                    t_d[i][j] = gf4_mul(ah_i[4*i +: 4], al_i[4*j +: 4])
                              ^ z_i[4*pair_idx(j, i, SHARES) +: 4];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            t_q <= '{default: '0};
        end else begin
            t_q <= t_d;
        end
    end

    always_comb begin
        e_o = '0;
        for (int i = 0; i < SHARES; i++) begin
            for (int j = 0; j < SHARES; j++) begin
                e_o[4*i +: 4] = e_o[4*i +: 4] ^ t_q[i][j];
            end
        end
    end

endmodule

// File: rtl/masked_gf4_inv_prep.sv
// Masked stage feeding the GF(2^4) inverter: computes E shares and aligns Ah/Al to the inverter output.
module masked_gf4_inv_prep
    import masked_gf4_inv_prep_pkg::*;
#(
    parameter int SHARES      = 2,
    parameter int INV_LATENCY = 2
) (
    input  logic                            ClkxCI,
    input  logic                            RstxBI,
    input  logic [8*SHARES-1:0]             _XxDI,
    input  logic [2*SHARES*(SHARES-1)-1:0]  _ZxDI,
    input  logic                            InValidxSI,
    output logic [GF4_W*SHARES-1:0]         _ExDO,
    output logic [GF4_W*SHARES-1:0]         _AhxDO,
    output logic [GF4_W*SHARES-1:0]         _AlxDO,
    output logic                            EValidxSO,
    output logic                            AValidxSO
);

    localparam int NW = GF4_W * SHARES;

    logic [NW-1:0]        ah_d;
    logic [NW-1:0]        al_d;
    logic [NW-1:0]        ah_q [INV_LATENCY+1];
    logic [NW-1:0]        al_q [INV_LATENCY+1];
    logic [INV_LATENCY:0] vld_q;

    always_comb begin
        ah_d = '0;
        al_d = '0;
        for (int i = 0; i < SHARES; i++) begin
            ah_d[4*i +: 4] = _XxDI[8*i+4 +: 4];
            al_d[4*i +: 4] = _XxDI[8*i +: 4];
        end
    end

    dom_gf4_sqscmul #(
        .SHARES (SHARES)
    ) u_dom (
        .clk_i  (ClkxCI),
        .rst_ni (RstxBI),
        .ah_i   (ah_d),
        .al_i   (al_d),
        .z_i    (_ZxDI),
        .e_o    (_ExDO)
    );

    // Free-running delay line; stage 0 matches the DOM register, the rest cover the inverter.
    always_ff @(posedge ClkxCI) begin
        if (!RstxBI) begin
            for (int n = 0; n <= INV_LATENCY; n++) begin
                ah_q[n] <= '0;
                al_q[n] <= '0;
            end
            vld_q <= '0;
        end else begin
            ah_q[0]  <= ah_d;
            al_q[0]  <= al_d;
            vld_q[0] <= InValidxSI;
            for (int n = 1; n <= INV_LATENCY; n++) begin
                ah_q[n]  <= ah_q[n-1];
                al_q[n]  <= al_q[n-1];
                vld_q[n] <= vld_q[n-1];
            end
        end
    end

    assign _AhxDO    = ah_q[INV_LATENCY];
    assign _AlxDO    = al_q[INV_LATENCY];
    assign EValidxSO = vld_q[0];
    assign AValidxSO = vld_q[INV_LATENCY];

endmodule

// File: tb/tb_masked_gf4_inv_prep.sv
// Self-checking bench for masked_gf4_inv_prep: SHARES=2/3 with INV_LATENCY=2, and SHARES=2 with INV_LATENCY=0.
module tb_masked_gf4_inv_prep;

    logic clk = 1'b0;
    logic rst_b;
    logic vin;

    logic [15:0] x2, x0;
    logic [23:0] x3;
    logic [3:0]  z2, z0;
    logic [11:0] z3;

    logic [7:0]  e2, ah2, al2, e0, ah0, al0;
    logic [11:0] e3, ah3, al3;
    logic        ev2, av2, ev3, av3, ev0, av0;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] cur_u;
    logic [3:0] exp_e;
    logic       exp_ev;
    logic [3:0] exp_ah [3];
    logic [3:0] exp_al [3];
    logic       exp_av [3];

    always #5 clk = ~clk;

    masked_gf4_inv_prep #(.SHARES(2), .INV_LATENCY(2)) dut2 (
        .ClkxCI(clk), .RstxBI(rst_b), ._XxDI(x2), ._ZxDI(z2), .InValidxSI(vin),
        ._ExDO(e2), ._AhxDO(ah2), ._AlxDO(al2), .EValidxSO(ev2), .AValidxSO(av2));

    masked_gf4_inv_prep #(.SHARES(3), .INV_LATENCY(2)) dut3 (
        .ClkxCI(clk), .RstxBI(rst_b), ._XxDI(x3), ._ZxDI(z3), .InValidxSI(vin),
        ._ExDO(e3), ._AhxDO(ah3), ._AlxDO(al3), .EValidxSO(ev3), .AValidxSO(av3));

    masked_gf4_inv_prep #(.SHARES(2), .INV_LATENCY(0)) dut0 (
        .ClkxCI(clk), .RstxBI(rst_b), ._XxDI(x0), ._ZxDI(z0), .InValidxSI(vin),
        ._ExDO(e0), ._AhxDO(ah0), ._AlxDO(al0), .EValidxSO(ev0), .AValidxSO(av0));

    function automatic logic [1:0] g_mul2(input logic [1:0] a, input logic [1:0] b);
        logic p;
        p = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ p, (a[0] & b[0]) ^ p};
    endfunction

    function automatic logic [3:0] g_mul4(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] m;
        logic [1:0] s;
        m = g_mul2(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]);
        s = {m[1] ^ m[0], m[1]};
        return {g_mul2(a[3:2], b[3:2]) ^ s, g_mul2(a[1:0], b[1:0]) ^ s};
    endfunction

    function automatic logic [3:0] g_sqsc(input logic [3:0] x);
        return {x[2] ^ x[0], x[3] ^ x[1], x[1], x[0] ^ x[1]};
    endfunction

    function automatic logic [3:0] golden(input logic [7:0] u);
        return g_sqsc(u[7:4] ^ u[3:0]) ^ g_mul4(u[7:4], u[3:0]);
    endfunction

    function automatic logic [3:0] fold(input logic [11:0] v, input int s);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < s; i++) r = r ^ v[4*i +: 4];
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [7:0] u, input logic v, input bit rnd);
        logic [7:0] r0, r1, r2;
        r0 = rnd ? 8'($urandom) : 8'h00;
        r1 = rnd ? 8'($urandom) : 8'h00;
        r2 = rnd ? 8'($urandom) : 8'h00;
        x2 = {u ^ r0, r0};
        x3 = {u ^ r1 ^ r2, r2, r1};
        x0 = {u ^ r2, r2};
        z2 = rnd ? 4'($urandom) : 4'h0;
        z3 = rnd ? 12'($urandom) : 12'h000;
        z0 = rnd ? 4'($urandom) : 4'h0;
        vin   = v;
        cur_u = u;
    endtask

    // Advance one edge, update the reference pipeline, then compare every output.
    task automatic tick();
        @(posedge clk);
        if (!rst_b) begin
            exp_e  = '0;
            exp_ev = 1'b0;
            for (int n = 0; n < 3; n++) begin
                exp_ah[n] = '0;
                exp_al[n] = '0;
                exp_av[n] = 1'b0;
            end
        end else begin
            for (int n = 2; n > 0; n--) begin
                exp_ah[n] = exp_ah[n-1];
                exp_al[n] = exp_al[n-1];
                exp_av[n] = exp_av[n-1];
            end
            exp_ah[0] = cur_u[7:4];
            exp_al[0] = cur_u[3:0];
            exp_av[0] = vin;
            exp_e     = golden(cur_u);
            exp_ev    = vin;
        end
        #1;
        check_eq("e_s2", 32'(fold({4'h0, e2}, 2)), 32'(exp_e));
        check_eq("e_s3", 32'(fold(e3, 3)), 32'(exp_e));
        check_eq("e_l0", 32'(fold({4'h0, e0}, 2)), 32'(exp_e));
        check_eq("evalid", 32'({ev2, ev3, ev0}), 32'({3{exp_ev}}));
        check_eq("avalid", 32'({av2, av3, av0}), 32'({exp_av[2], exp_av[2], exp_av[0]}));
        check_eq("ah_l2", 32'({fold({4'h0, ah2}, 2), fold(ah3, 3)}), 32'({exp_ah[2], exp_ah[2]}));
        check_eq("al_l2", 32'({fold({4'h0, al2}, 2), fold(al3, 3)}), 32'({exp_al[2], exp_al[2]}));
        check_eq("ahl_l0", 32'({fold({4'h0, ah0}, 2), fold({4'h0, al0}, 2)}), 32'({exp_ah[0], exp_al[0]}));
    endtask

    initial begin
        rst_b = 1'b0;
        apply(8'h00, 1'b0, 1'b0);
        tick();
        tick();
        check_eq("rst_state", 32'({e2, ah2, al2, ev2, av2, ev0, av0}), 32'h0);

        rst_b = 1'b1;
        apply(8'h10, 1'b1, 1'b0);
        tick();
        check_eq("x10_e", 32'(fold({4'h0, e2}, 2)), 32'h9);
        check_eq("x10_ev", 32'(ev2), 32'h1);
        check_eq("x10_l0", 32'({fold({4'h0, ah0}, 2), fold({4'h0, al0}, 2), av0}), {23'h0, 4'h1, 4'h0, 1'b1});

        apply(8'h11, 1'b1, 1'b1);
        tick();
        check_eq("x11_e2", 32'(fold({4'h0, e2}, 2)), 32'hD);
        check_eq("x11_e3", 32'(fold(e3, 3)), 32'hD);
        apply(8'h00, 1'b0, 1'b1);
        tick();
        tick();
        check_eq("x11_a", 32'({fold({4'h0, ah2}, 2), fold({4'h0, al2}, 2), av2}), {23'h0, 4'h1, 4'h1, 1'b1});
        tick();
        check_eq("x11_a_end", 32'(av2), 32'h0);

        for (int n = 0; n < 256; n++) begin
            apply(8'(n), 1'b1, 1'b1);
            tick();
        end
        apply(8'hA5, 1'b1, 1'b1);
        tick();

        // Reset with valids in flight and a valid presented on the reset edge.
        rst_b = 1'b0;
        apply(8'h5A, 1'b1, 1'b1);
        tick();
        check_eq("rst_mid", 32'({ev2, av2, ev3, av3, ev0, av0}), 32'h0);
        check_eq("rst_mid_data", 32'({e2, ah2, al2}), 32'h0);
        rst_b = 1'b1;
        apply(8'h37, 1'b1, 1'b1);
        tick();
        check_eq("post_rst_e", 32'(fold({4'h0, e2}, 2)), 32'h4);
        check_eq("post_rst_ev", 32'({ev2, av2}), 32'h2);
        apply(8'h00, 1'b0, 1'b1);
        tick();
        check_eq("post_rst_a1", 32'(av2), 32'h0);
        tick();
        check_eq("post_rst_a", 32'({fold({4'h0, ah2}, 2), fold({4'h0, al2}, 2), av2}), {23'h0, 4'h3, 4'h7, 1'b1});
        for (int n = 0; n < 4; n++) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
